// File: rtl/block_lock_fsm_pkg.sv
// Shared PCS definitions for the block-lock state machine: parameter
// defaults and the state encoding.
package block_lock_fsm_pkg;

    localparam int LEN_CODED_BLOCK_DEF = 66;
    localparam int N_LOCK_SH_DEF       = 64;
    localparam int LEN_WINDOW_DEF      = 1024;
    localparam int MAX_INVALID_DEF     = 65;

    // Counter clearing is folded into the transitions, so only two states
    // are needed.
    typedef enum logic {
        ST_TEST = 1'b0,
        ST_SLIP = 1'b1
    } lock_state_e;

endpackage

// File: rtl/block_lock_fsm.sv
// Block-lock FSM: hunts for the sync-header alignment by slipping the block
// shifter index until N_LOCK_SH consecutive valid headers are seen. While
// locked, it watches windows of LEN_WINDOW blocks. Lock drops when
// MAX_INVALID invalid headers occur inside one window.
module block_lock_fsm
    import block_lock_fsm_pkg::*;
#(
    parameter int LEN_CODED_BLOCK = LEN_CODED_BLOCK_DEF,
    parameter int N_LOCK_SH       = N_LOCK_SH_DEF,
    parameter int LEN_WINDOW      = LEN_WINDOW_DEF,
    parameter int MAX_INVALID     = MAX_INVALID_DEF
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic                               i_valid,
    input  logic                               i_sh_valid,
    output logic [$clog2(LEN_CODED_BLOCK)-1:0] o_index,
    output logic                               o_block_lock,
    output logic                               o_slip
);

    localparam int IDX_W = $clog2(LEN_CODED_BLOCK);
    localparam int SH_W  = $clog2(LEN_WINDOW + 1);
    localparam int INV_W = $clog2(MAX_INVALID + 1);

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(LEN_CODED_BLOCK - 1);
    localparam logic [SH_W-1:0]  SH_LOCK    = SH_W'(N_LOCK_SH);
    localparam logic [SH_W-1:0]  SH_WINDOW  = SH_W'(LEN_WINDOW);
    localparam logic [INV_W-1:0] INV_LIMIT  = INV_W'(MAX_INVALID);

    lock_state_e       state_q;
    logic [SH_W-1:0]   sh_cnt_q;
    logic [INV_W-1:0]  invalid_cnt_q;
    logic [IDX_W-1:0]  index_q;
    logic              block_lock_q;
    logic              slip_q;

    // Counter values as they would be after counting the current block.
    // Every count that reaches its limit is cleared on that same edge, so
    // neither counter can wrap.
    logic [SH_W-1:0]   sh_cnt_inc;
    logic [INV_W-1:0]  invalid_cnt_inc;
    logic [IDX_W-1:0]  index_inc;

    assign sh_cnt_inc      = sh_cnt_q + SH_W'(1);
    assign invalid_cnt_inc = invalid_cnt_q + {{(INV_W-1){1'b0}}, ~i_sh_valid};
    assign index_inc       = (index_q == IDX_LAST) ? '0 : index_q + IDX_W'(1);

    assign o_index      = index_q;
    assign o_block_lock = block_lock_q;
    assign o_slip       = slip_q;

    // State, counters and registered outputs; outputs update on the edge that samples the block.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q       <= ST_TEST;
            sh_cnt_q      <= '0;
            invalid_cnt_q <= '0;
            index_q       <= '0;
            block_lock_q  <= 1'b0;
            slip_q        <= 1'b0;
        end else begin
            // o_slip is a one-cycle pulse; only a slip edge sets it again.
            slip_q <= 1'b0;
            case (state_q)
                ST_SLIP: begin
                    // The shifter is realigning: blocks seen now are ignored.
                    state_q <= ST_TEST;
                end
                ST_TEST: begin
                    if (i_valid) begin
                        if (!block_lock_q) begin
                            if (!i_sh_valid) begin
                                state_q       <= ST_SLIP;
                                slip_q        <= 1'b1;
                                index_q       <= index_inc;
                                sh_cnt_q      <= '0;
                                invalid_cnt_q <= '0;
                            end else if (sh_cnt_inc == SH_LOCK) begin
                                block_lock_q  <= 1'b1;
                                sh_cnt_q      <= '0;
                                invalid_cnt_q <= '0;
                            end else begin
                                sh_cnt_q      <= sh_cnt_inc;
                                invalid_cnt_q <= invalid_cnt_inc;
                            end
                        end else begin
                            // Losing lock outranks the end-of-window clear.
                            if (!i_sh_valid && (invalid_cnt_inc == INV_LIMIT)) begin
                                state_q       <= ST_SLIP;
                                block_lock_q  <= 1'b0;
                                slip_q        <= 1'b1;
                                index_q       <= index_inc;
                                sh_cnt_q      <= '0;
                                invalid_cnt_q <= '0;
                            end else if (sh_cnt_inc == SH_WINDOW) begin
                                sh_cnt_q      <= '0;
                                invalid_cnt_q <= '0;
                            end else begin
                                sh_cnt_q      <= sh_cnt_inc;
                                invalid_cnt_q <= invalid_cnt_inc;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_TEST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_lock_fsm.sv
// Directed bench for block_lock_fsm: a table of short vectors covering reset and
// slip basics, followed by hand-written long sequences for lock acquisition,
// window handling, lock loss and reset override.
module tb_block_lock_fsm;
    import block_lock_fsm_pkg::*;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_valid = 1'b0;
    logic       i_sh_valid = 1'b0;
    logic [6:0] o_index;
    logic       o_block_lock;
    logic       o_slip;

    int n_checks = 0;
    int n_fail   = 0;

    block_lock_fsm dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .i_sh_valid   (i_sh_valid),
        .o_index      (o_index),
        .o_block_lock (o_block_lock),
        .o_slip       (o_slip)
    );

    always #5 i_clock = ~i_clock;

    typedef struct packed {
        logic       rst;
        logic       vld;
        logic       shv;
        logic       exp_lock;
        logic       exp_slip;
        logic [6:0] exp_idx;
    } vec_t;

    vec_t vecs [10];

    // One clock edge with the given inputs; outputs are settled 1 time unit later.
    task automatic drive(input logic r, input logic v, input logic s);
        @(negedge i_clock);
        i_reset    = r;
        i_valid    = v;
        i_sh_valid = s;
        @(posedge i_clock);
        #1;
    endtask

    task automatic check(input string name, input logic lock, input logic slip,
                         input logic [6:0] idx);
        n_checks++;
        if ({o_block_lock, o_slip, o_index} !== {lock, slip, idx}) begin
            n_fail++;
            $display("FAIL %s: got lock=%0b slip=%0b index=%0d, expected lock=%0b slip=%0b index=%0d",
                     name, o_block_lock, o_slip, o_index, lock, slip, idx);
        end else begin
            $display("ok   %s: lock=%0b slip=%0b index=%0d", name, o_block_lock, o_slip, o_index);
        end
    endtask

    task automatic check_cnt(input string name, input int sh, input int inv);
        n_checks++;
        if (int'(dut.sh_cnt_q) != sh || int'(dut.invalid_cnt_q) != inv) begin
            n_fail++;
            $display("FAIL %s: got sh_cnt=%0d invalid_cnt=%0d, expected sh_cnt=%0d invalid_cnt=%0d",
                     name, dut.sh_cnt_q, dut.invalid_cnt_q, sh, inv);
        end else begin
            $display("ok   %s: sh_cnt=%0d invalid_cnt=%0d", name, sh, inv);
        end
    endtask

    // Reset, then exactly 64 valid headers: the last one acquires lock.
    task automatic acquire_lock(input logic [6:0] idx);
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) drive(1'b0, 1'b1, 1'b1);
        check("acquire_lock", 1'b1, 1'b0, idx);
    endtask

    initial begin
        int slip_seen;

        //              rst   vld   shv   lock  slip  idx
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};  // reset
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'd1};  // invalid -> slip
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'd1};  // SLIP cycle, ignored
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd1};  // no block
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'd2};  // invalid -> slip
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd2};  // back to TEST
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd2};  // sh_valid=0 but no block
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0};  // reset overrides invalid
        vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'd1};  // invalid -> slip
        vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0};  // reset during SLIP

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].shv);
            check($sformatf("vec%0d", i), vecs[i].exp_lock, vecs[i].exp_slip, vecs[i].exp_idx);
        end

        // Lock after exactly 64 valid blocks, no slip along the way.
        drive(1'b1, 1'b0, 1'b0);
        slip_seen = 0;
        for (int i = 1; i <= 63; i++) begin
            drive(1'b0, 1'b1, 1'b1);
            if (o_slip) slip_seen++;
        end
        check("lock_after_63", 1'b0, 1'b0, 7'd0);
        drive(1'b0, 1'b1, 1'b1);
        check("lock_at_64", 1'b1, 1'b0, 7'd0);
        n_checks++;
        if (slip_seen != 0) begin
            n_fail++;
            $display("FAIL no_slip_during_lock: got %0d slip pulses, expected 0", slip_seen);
        end
        check_cnt("counters_after_lock", 0, 0);

        // Block 10 invalid; the SLIP-cycle block is not counted, so 64 more needed.
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        check("slip_at_block10", 1'b0, 1'b1, 7'd1);
        drive(1'b0, 1'b1, 1'b1);
        check("slip_one_cycle", 1'b0, 1'b0, 7'd1);
        for (int i = 1; i <= 63; i++) drive(1'b0, 1'b1, 1'b1);
        check("relock_after_63", 1'b0, 1'b0, 7'd1);
        drive(1'b0, 1'b1, 1'b1);
        check("relock_at_64", 1'b1, 1'b0, 7'd1);

        // 66 slips walk the index through 0..65 and wrap to 0.
        drive(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 66; k++) begin
            drive(1'b0, 1'b1, 1'b0);
            check($sformatf("walk_slip%0d", k), 1'b0, 1'b1, 7'(k % 66));
            drive(1'b0, 1'b1, 1'b0);  // invalid during SLIP is ignored
        end
        check("walk_after_wrap", 1'b0, 1'b0, 7'd0);

        // Window 1: 64 invalid of 1024 keeps lock and clears counters at 1024.
        acquire_lock(7'd0);
        for (int b = 1; b <= 1024; b++) begin
            drive(1'b0, 1'b1, (b > 64));
            if (b == 64) check("win1_64_invalid", 1'b1, 1'b0, 7'd0);
            if (b == 1023) check_cnt("win1_counts_1023", 1023, 64);
        end
        check("win1_end", 1'b1, 1'b0, 7'd0);
        check_cnt("win1_counters_cleared", 0, 0);
        // Window 2: 64 invalid, a gap, then the 65th invalid drops lock.
        for (int b = 1; b <= 64; b++) drive(1'b0, 1'b1, 1'b0);
        check("win2_64_invalid", 1'b1, 1'b0, 7'd0);
        for (int b = 1; b <= 100; b++) drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check("win2_idle_holds", 1'b1, 1'b0, 7'd0);
        drive(1'b0, 1'b1, 1'b0);
        check("win2_65th_invalid", 1'b0, 1'b1, 7'd1);
        check_cnt("win2_counters_cleared", 0, 0);

        // 65th invalid landing on block 1024 slips rather than closing the window.
        acquire_lock(7'd0);
        for (int b = 1; b <= 1023; b++) drive(1'b0, 1'b1, (b > 64));
        check("edge_block1023", 1'b1, 1'b0, 7'd0);
        drive(1'b0, 1'b1, 1'b0);
        check("edge_block1024_slip", 1'b0, 1'b1, 7'd1);

        // Reach index 37, lock, then reset mid-window.
        drive(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 37; k++) begin
            drive(1'b0, 1'b1, 1'b0);
            drive(1'b0, 1'b0, 1'b0);
        end
        check("index_37", 1'b0, 1'b0, 7'd37);
        for (int i = 0; i < 64; i++) drive(1'b0, 1'b1, 1'b1);
        check("lock_at_37", 1'b1, 1'b0, 7'd37);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, (i % 3 != 0));
        check_cnt("mid_window_counts", 10, 4);
        drive(1'b1, 1'b1, 1'b0);
        check("reset_while_locked", 1'b0, 1'b0, 7'd0);
        check_cnt("reset_counters", 0, 0);
        n_checks++;
        if (dut.state_q !== ST_TEST) begin
            n_fail++;
            $display("FAIL reset_state: got %0d, expected %0d", dut.state_q, ST_TEST);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/block_lock_fsm.md
BLOCK_LOCK_FSM -- requirements
Module: block_lock_fsm

Interface
REQ-001 Parameter LEN_CODED_BLOCK, default 66, sets coded block length and the number of slip positions.
REQ-002 Parameter N_LOCK_SH, default 64, sets the consecutive valid sync headers needed to acquire lock.
REQ-003 Parameter LEN_WINDOW, default 1024, sets the monitoring window length, in blocks, while locked.
REQ-004 Parameter MAX_INVALID, default 65, sets the invalid headers within one window that force loss of lock.
REQ-005 i_clock  in  1  clock; all state changes on the rising edge.
REQ-006 i_reset  in  1  reset, synchronous, active-high.
REQ-007 i_valid  in  1  a new 66-bit block is present at the sync/shift stage this cycle.
REQ-008 i_sh_valid  in  1  the block's sync header is 01 or 10; meaningful only when i_valid=1.
REQ-009 o_index  out  $clog2(LEN_CODED_BLOCK) (7)  bit offset driven to the block shifter, range 0..LEN_CODED_BLOCK-1.
REQ-010 o_block_lock  out  1  registered lock status.
REQ-011 o_slip  out  1  single-cycle registered pulse; o_index advanced this cycle.

Function
REQ-012 States SHALL be TEST and SLIP only; counter reset is folded into transitions.
REQ-013 In TEST, each cycle with i_valid=1 SHALL increment sh_cnt, and SHALL also increment invalid_cnt when i_sh_valid=0.
REQ-014 Cycles with i_valid=0 SHALL leave all state, counters and outputs unchanged, except o_slip, which clears.
REQ-015 Unlocked with i_valid=1 and i_sh_valid=0: on that edge, next state SHALL be SLIP, counters SHALL clear and o_slip SHALL be set to 1.
REQ-016 On the same edge, o_index SHALL be set to (o_index+1) mod LEN_CODED_BLOCK, wrapping from 65 to 0.
REQ-017 Unlocked: the edge that samples the N_LOCK_SH-th consecutive valid header SHALL set o_block_lock=1 and clear both counters.
REQ-018 Locked: the edge that samples the MAX_INVALID-th invalid header in the current window SHALL clear o_block_lock and perform the slip of REQ-015/016.
REQ-019 Locked: the edge that samples the LEN_WINDOW-th block with invalid_cnt below MAX_INVALID SHALL clear both counters and keep lock.
REQ-020 When the LEN_WINDOW-th block is also the MAX_INVALID-th invalid header, the slip SHALL take precedence.
REQ-021 SLIP SHALL last exactly one cycle; i_valid during SLIP SHALL be ignored (not counted).
REQ-022 The next edge after SLIP SHALL return the FSM to TEST and clear o_slip.
REQ-023 Latency: outputs SHALL change on the edge that samples the triggering block, with no further delay.
REQ-024 Counter widths: sh_cnt $clog2(LEN_WINDOW+1) bits, invalid_cnt $clog2(MAX_INVALID+1) bits; neither counter SHALL overflow.

Reset
REQ-025 The edge with i_reset=1 SHALL set state=TEST, sh_cnt=0, invalid_cnt=0, o_index=0, o_block_lock=0 and o_slip=0.
REQ-026 Reset SHALL override every other input, including mid-window, while locked and during SLIP.

Structure
REQ-027 LEN_CODED_BLOCK, N_LOCK_SH, LEN_WINDOW, MAX_INVALID defaults and the state encoding SHALL reside in the shared PCS package.
REQ-028 The block SHALL be a single module with no sub-module.
REQ-029 o_index SHALL connect directly to the block shifter's index input; i_sh_valid SHALL come from the sync-header checker.

Verification
REQ-030 Reset, then 64 valid blocks -> o_block_lock=1 on the 64th edge; o_index=0; o_slip never asserted.
REQ-031 Unlocked, block 10 invalid -> o_slip high one cycle and o_index 0->1; lock only after 64 further valid blocks.
REQ-032 66 spaced invalid blocks while unlocked -> o_index 0..65 then 0; i_valid held high during each SLIP cycle is not counted.
REQ-033 Locked, 64 invalid in window 1 -> lock held and counters clear at block 1024; 65 invalid in window 2 -> lock drops on the 65th, slip, o_index+1.
REQ-034 Locked, 65th invalid arrives as block 1024 -> slip and lock loss, not window reset.
REQ-035 Locked with o_index=37, assert i_reset -> next edge gives o_block_lock=0, o_index=0, o_slip=0, counters 0.
